// File: rtl/hall_sequence_generator.sv
// Hall-sensor emulator: steps a 6-sector hall code at a programmable period/direction,
// with manual stepping and a signed electrical-revolution count. Optional macro: HALL_FAULT_INJECT_EN.
module hall_sequence_generator #(
    parameter int PERIOD_W = 16,
    parameter int REV_W    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                direction,
    input  logic [PERIOD_W-1:0] period,
    input  logic                step_pulse,
`ifdef HALL_FAULT_INJECT_EN
    input  logic                fault_en,
    input  logic                fault_code,
`endif
    output logic [2:0]          h,
    output logic [2:0]          sector,
    output logic                step_strobe,
    output logic [REV_W-1:0]    rev_count
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [2:0]          sector_q, sector_d;
    logic [2:0]          h_q, h_d;
    logic                strobe_q, strobe_d;
    logic [REV_W-1:0]    rev_q, rev_d;
    logic                step;

    function automatic logic [2:0] hall_code(input logic [2:0] s);
        case (s)
            3'd0:    hall_code = 3'b101;
            3'd1:    hall_code = 3'b100;
            3'd2:    hall_code = 3'b110;
            3'd3:    hall_code = 3'b010;
            3'd4:    hall_code = 3'b011;
            3'd5:    hall_code = 3'b001;
            default: hall_code = 3'b101;
        endcase
    endfunction

    // Step timer: period is latched at the start of each step, so a new period only
    // applies once the current step has finished.
    always_comb begin
        step     = 1'b0;
        cnt_d    = cnt_q;
        period_d = period_q;
        if (enable) begin
            if (cnt_q == '0) begin
                period_d = period;
                if (period == PERIOD_W'(1)) begin
                    step = 1'b1;
                end else if (period != '0) begin
                    cnt_d = PERIOD_W'(1);
                end
            end else if (cnt_q == period_q - PERIOD_W'(1)) begin
                step  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + PERIOD_W'(1);
            end
        end else if (step_pulse) begin
            step = 1'b1;
        end
    end

    always_comb begin
        sector_d = sector_q;
        rev_d    = rev_q;
        if (step) begin
            if (direction) begin
                if (sector_q == 3'd5) begin
                    sector_d = 3'd0;
                    rev_d    = rev_q + REV_W'(1);
                end else begin
                    sector_d = sector_q + 3'd1;
                end
            end else begin
                if (sector_q == 3'd0) begin
                    sector_d = 3'd5;
                    rev_d    = rev_q - REV_W'(1);
                end else begin
                    sector_d = sector_q - 3'd1;
                end
            end
        end
        strobe_d = step;
`ifdef HALL_FAULT_INJECT_EN
        h_d = fault_en ? {3{fault_code}} : hall_code(sector_d);
`else
        h_d = hall_code(sector_d);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= '0;
            period_q <= '0;
            sector_q <= 3'd0;
            h_q      <= 3'b101;
            strobe_q <= 1'b0;
            rev_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            sector_q <= sector_d;
            h_q      <= h_d;
            strobe_q <= strobe_d;
            rev_q    <= rev_d;
        end
    end

    assign h           = h_q;
    assign sector      = sector_q;
    assign step_strobe = strobe_q;
    assign rev_count   = rev_q;

endmodule

// File: tb/tb_hall_sequence_generator.sv
// Bench for hall_sequence_generator: cycle-level behavioural model plus directed literal checks
// and a randomized soak. Fault-injection checks are compiled in with HALL_FAULT_INJECT_EN.
module tb_hall_sequence_generator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        direction = 1'b1;
    logic [15:0] period = 16'd0;
    logic        step_pulse = 1'b0;
`ifdef HALL_FAULT_INJECT_EN
    logic        fault_en = 1'b0;
    logic        fault_code = 1'b0;
`endif
    logic [2:0]  h;
    logic [2:0]  sector;
    logic        step_strobe;
    logic [15:0] rev_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hall_sequence_generator #(.PERIOD_W(16), .REV_W(16)) dut (
        .clock      (clk),
        .reset      (reset),
        .enable     (enable),
        .direction  (direction),
        .period     (period),
        .step_pulse (step_pulse),
`ifdef HALL_FAULT_INJECT_EN
        .fault_en   (fault_en),
        .fault_code (fault_code),
`endif
        .h          (h),
        .sector     (sector),
        .step_strobe(step_strobe),
        .rev_count  (rev_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference model: sector as a plain integer, hall code from a table, timer as
    // "cycles spent in this step" against the period captured when the step began.
    logic [2:0]  code_tab [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    int          m_sec = 0;
    int          m_elapsed = 0;
    int          m_per = 0;
    logic [15:0] m_rev = 16'd0;
    logic [2:0]  m_h = 3'b101;
    bit          m_strobe = 1'b0;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        bit stepped;
        stepped = 1'b0;
        if (reset) begin
            m_sec = 0; m_elapsed = 0; m_per = 0; m_rev = 16'd0;
            m_valid = 1'b1;
        end else begin
            if (enable) begin
                if (m_elapsed == 0) begin
                    m_per = int'(period);
                    if (m_per == 1) stepped = 1'b1;
                    else if (m_per > 1) m_elapsed = 1;
                end else if (m_elapsed + 1 == m_per) begin
                    stepped = 1'b1;
                    m_elapsed = 0;
                end else begin
                    m_elapsed++;
                end
            end else if (step_pulse) begin
                stepped = 1'b1;
            end
            if (stepped) begin
                if (direction) begin
                    if (m_sec == 5) m_rev = m_rev + 16'd1;
                    m_sec = (m_sec + 1) % 6;
                end else begin
                    if (m_sec == 0) m_rev = m_rev - 16'd1;
                    m_sec = (m_sec + 5) % 6;
                end
            end
        end
        m_strobe = stepped;
        m_h = code_tab[m_sec];
`ifdef HALL_FAULT_INJECT_EN
        if (!reset && fault_en) m_h = {3{fault_code}};
`endif
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("h", 32'(h), 32'(m_h));
            chk("sector", 32'(sector), 32'(m_sec));
            chk("step_strobe", 32'(step_strobe), 32'(m_strobe));
            chk("rev_count", 32'(rev_count), 32'(m_rev));
        end
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; step_pulse = 1'b0;
`ifdef HALL_FAULT_INJECT_EN
        fault_en = 1'b0;
`endif
        cyc(1);
        reset = 1'b0;
    endtask

    initial begin
        int first_at, second_at, strobes;
        @(negedge clk);
        do_reset();
        chk("reset_h", 32'(h), 32'h5);
        chk("reset_sector", 32'(sector), 32'd0);
        chk("reset_rev", 32'(rev_count), 32'd0);

        // Forward at period 4.
        direction = 1'b1; period = 16'd4; enable = 1'b1;
        cyc(3);
        chk("fwd_no_strobe_yet", 32'(step_strobe), 32'd0);
        cyc(1);
        chk("fwd_first_strobe", 32'(step_strobe), 32'd1);
        chk("fwd_first_h", 32'(h), 32'h4);
        cyc(20);
        chk("fwd_rev_after_6", 32'(rev_count), 32'd1);
        chk("fwd_h_wrapped", 32'(h), 32'h5);

        // Reverse at period 2.
        do_reset();
        direction = 1'b0; period = 16'd2; enable = 1'b1;
        cyc(2);
        chk("rev_first_h", 32'(h), 32'h1);
        cyc(10);
        chk("rev_rev_count", 32'(rev_count), 32'hFFFF);
        chk("rev_h_wrapped", 32'(h), 32'h5);

        // Period change mid-step: 10 -> 3 after 5 cycles.
        do_reset();
        direction = 1'b1; period = 16'd10; enable = 1'b1;
        cyc(5);
        period = 16'd3;
        first_at = -1; second_at = -1;
        for (int k = 6; k <= 30; k++) begin
            cyc(1);
            if (step_strobe) begin
                if (first_at < 0) first_at = k;
                else if (second_at < 0) second_at = k;
            end
        end
        chk("per_change_first", 32'(first_at), 32'd10);
        chk("per_change_second", 32'(second_at), 32'd13);

        // Period 0 halts.
        period = 16'd0;
        cyc(4);
        strobes = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            if (step_strobe) strobes++;
        end
        chk("halt_no_strobes", 32'(strobes), 32'd0);

        // Manual stepping.
        do_reset();
        direction = 1'b1; enable = 1'b0; strobes = 0;
        for (int k = 0; k < 3; k++) begin
            step_pulse = 1'b1; cyc(1);
            if (step_strobe) strobes++;
            step_pulse = 1'b0; cyc(1);
            if (step_strobe) strobes++;
        end
        chk("manual_sector", 32'(sector), 32'd3);
        chk("manual_h", 32'(h), 32'h2);
        chk("manual_strobes", 32'(strobes), 32'd3);
        enable = 1'b1; period = 16'd0; step_pulse = 1'b1;
        cyc(1);
        step_pulse = 1'b0;
        chk("pulse_ignored_when_enabled", 32'(sector), 32'd3);

        // Reset mid-step at sector 4, cnt 2.
        do_reset();
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step_pulse = 1'b1; cyc(1); step_pulse = 1'b0;
        end
        enable = 1'b1; period = 16'd5;
        cyc(2);
        chk("pre_reset_sector", 32'(sector), 32'd4);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("midreset_sector", 32'(sector), 32'd0);
        chk("midreset_h", 32'(h), 32'h5);
        chk("midreset_rev", 32'(rev_count), 32'd0);
        period = 16'd2;
        cyc(1);
        chk("midreset_cnt0_a", 32'(step_strobe), 32'd0);
        cyc(1);
        chk("midreset_cnt0_b", 32'(step_strobe), 32'd1);

`ifdef HALL_FAULT_INJECT_EN
        do_reset();
        direction = 1'b1; period = 16'd3; enable = 1'b1;
        cyc(2);
        fault_en = 1'b1; fault_code = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            chk("fault_h_forced", 32'(h), 32'h7);
        end
        fault_en = 1'b0;
        cyc(1);
        chk("fault_release_sector", 32'(sector), 32'd2);
        chk("fault_release_h", 32'(h), 32'h6);
`endif

        // Randomized soak against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            int pv;
            pv = $urandom_range(0, 5);
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            if ($urandom_range(0, 7) == 0) direction = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 31) == 0) period = (pv == 5) ? 16'd7 : 16'(pv);
            step_pulse = $urandom_range(0, 3) == 0;
            reset = $urandom_range(0, 499) == 0;
`ifdef HALL_FAULT_INJECT_EN
            if ($urandom_range(0, 63) == 0) fault_en = ~fault_en;
            fault_code = $urandom_range(0, 1) == 1;
`endif
            cyc(1);
        end
        reset = 1'b0; step_pulse = 1'b0;
        cyc(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
